mat_vec_mul: RTL and testbench



---
 rtl/mat_vec_mul.sv | 134 +++++++++++++
 tb/tb_mat_vec_mul.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_vec_mul.sv
// Signed fixed-point NxN matrix by N-vector multiplier, y = C*x, with loadable coefficients.
// One column per cycle is accumulated into N parallel accumulators; results are rounded and saturated.
module mat_vec_mul #(
   parameter int N     = 2,
   parameter int W     = 13,
   parameter int FRAC  = 4,
   parameter int OUT_W = 16,
   parameter int AW    = (N * N > 1) ? $clog2(N * N) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 coef_we,
   input  logic [AW-1:0]        coef_addr,
   input  logic [W-1:0]         coef_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N*W-1:0]       in_vec,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N*OUT_W-1:0]   out_vec
);

   localparam int CW   = $clog2(N);
   localparam int ACCW = 2 * W + CW;
   localparam int RW   = ACCW + 1;
   localparam logic signed [RW-1:0] HALF = RW'((2 ** FRAC) / 2);
   localparam logic signed [RW-1:0] OMAX = {{(RW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [RW-1:0] OMIN = {{(RW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t                  state_q, state_d;
   logic                    accept, last;
   logic signed [W-1:0]     coef_q [N*N];
   logic signed [W-1:0]     x_q [N];
   logic signed [ACCW-1:0]  acc_q [N];
   logic [CW-1:0]           col_q;
   logic [N*OUT_W-1:0]      out_q;

   logic signed [W-1:0]     x_sel;
   logic signed [W-1:0]     c_sel [N];
   logic signed [2*W-1:0]   prod [N];
   logic signed [ACCW-1:0]  sum [N];
   logic signed [RW-1:0]    rnd [N];
   logic signed [RW-1:0]    sat [N];
   logic [N*OUT_W-1:0]      fmt;

   assign in_ready  = (state_q == IDLE) & ~rst;
   assign out_valid = (state_q == DONE);
   assign out_vec   = out_q;

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      last    = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               accept  = 1'b1;
               state_d = MAC;
            end
         end
         MAC: begin
            if (col_q == CW'(N - 1)) begin
               last    = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Column-select muxes, N parallel MACs, then round-half-up and saturate.
   always_comb begin
      x_sel = '0;
      fmt   = '0;
      for (int c = 0; c < N; c++) begin
         if (col_q == CW'(c)) x_sel = x_q[c];
      end
      for (int r = 0; r < N; r++) begin
         c_sel[r] = '0;
         for (int c = 0; c < N; c++) begin
            if (col_q == CW'(c)) c_sel[r] = coef_q[r*N+c];
         end
         prod[r] = (2 * W)'(c_sel[r]) * (2 * W)'(x_sel);
         sum[r]  = acc_q[r] + ACCW'(prod[r]);
         rnd[r]  = (RW'(sum[r]) + HALF) >>> FRAC;
         if (rnd[r] > OMAX) begin
            sat[r] = OMAX;
         end else if (rnd[r] < OMIN) begin
            sat[r] = OMIN;
         end else begin
            sat[r] = rnd[r];
         end
         fmt[r*OUT_W +: OUT_W] = sat[r][OUT_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         out_q   <= '0;
         for (int i = 0; i < N * N; i++) coef_q[i] <= '0;
         for (int i = 0; i < N; i++) begin
            x_q[i]   <= '0;
            acc_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         // Out-of-range addresses match no entry and are dropped.
         if (coef_we && in_ready) begin
            for (int i = 0; i < N * N; i++) begin
               if (coef_addr == AW'(i)) coef_q[i] <= coef_data;
            end
         end
         if (accept) begin
            col_q <= '0;
            for (int i = 0; i < N; i++) begin
               x_q[i]   <= in_vec[i*W +: W];
               acc_q[i] <= '0;
            end
         end else if (state_q == MAC) begin
            col_q <= col_q + 1'b1;
            for (int i = 0; i < N; i++) acc_q[i] <= sum[i];
            if (last) out_q <= fmt;
         end
      end
   end

endmodule

// File: tb/tb_mat_vec_mul.sv
// Directed self-checking bench for mat_vec_mul at default parameters and at N=4, W=8.
module tb_mat_vec_mul;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        coef_we = 1'b0;
   logic [1:0]  coef_addr = '0;
   logic [12:0] coef_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [25:0] in_vec = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_vec;

   logic        coef_we4 = 1'b0;
   logic [3:0]  coef_addr4 = '0;
   logic [7:0]  coef_data4 = '0;
   logic        in_valid4 = 1'b0;
   logic        in_ready4;
   logic [31:0] in_vec4 = '0;
   logic        out_valid4;
   logic        out_ready4 = 1'b0;
   logic [47:0] out_vec4;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mat_vec_mul dut (
      .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec), .out_valid(out_valid),
      .out_ready(out_ready), .out_vec(out_vec)
   );

   mat_vec_mul #(.N(4), .W(8), .FRAC(2), .OUT_W(12)) dut4 (
      .clk(clk), .rst(rst), .coef_we(coef_we4), .coef_addr(coef_addr4),
      .coef_data(coef_data4), .in_valid(in_valid4), .in_ready(in_ready4), .in_vec(in_vec4),
      .out_valid(out_valid4), .out_ready(out_ready4), .out_vec(out_vec4)
   );

   task automatic write_coef(input logic [1:0] a, input logic [12:0] d);
      coef_we   = 1'b1;
      coef_addr = a;
      coef_data = d;
      @(negedge clk);
      coef_we   = 1'b0;
   endtask

   task automatic load_default;
      write_coef(2'd0, -13'sd2);
      write_coef(2'd1, 13'sd37);
      write_coef(2'd2, 13'sd50);
      write_coef(2'd3, -13'sd180);
   endtask

   task automatic load_all(input logic [12:0] d);
      for (int i = 0; i < 4; i++) write_coef(2'(i), d);
   endtask

   // Sends one vector from IDLE, waits (bounded) for the result, then completes the transfer.
   task automatic run_vec(input logic [12:0] x0, input logic [12:0] x1,
                          output logic [31:0] res, output int lat);
      in_vec   = {x1, x0};
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      res = out_vec;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      tests++;
      if (in_ready !== 1'b0) begin
         fails++; $display("FAIL reset_in_ready_during_rst: got %b want 0", in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1) begin
         fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      tests++;
      if (out_vec !== 32'h0) begin
         fails++; $display("FAIL reset_out_vec: got %h want 00000000", out_vec);
      end
   endtask

   task automatic test_defaults;
      logic [31:0] res;
      int lat;
      load_default();
      run_vec(13'sd16, 13'sd16, res, lat);
      tests++;
      if (res !== {16'hff7e, 16'h0023}) begin
         fails++; $display("FAIL defaults_out_vec: got %h want ff7e0023", res);
      end
      tests++;
      if (lat !== 3) begin
         fails++; $display("FAIL defaults_latency: got %0d want 3", lat);
      end
   endtask

   task automatic test_saturation;
      logic [31:0] res;
      int lat;
      load_all(13'sd4095);
      run_vec(13'sd4095, 13'sd4095, res, lat);
      tests++;
      if (res !== {16'h7fff, 16'h7fff}) begin
         fails++; $display("FAIL sat_pos: got %h want 7fff7fff", res);
      end
      load_all(-13'sd4096);
      run_vec(13'sd4095, 13'sd4095, res, lat);
      tests++;
      if (res !== {16'h8000, 16'h8000}) begin
         fails++; $display("FAIL sat_neg: got %h want 80008000", res);
      end
   endtask

   task automatic test_backpressure;
      int lat;
      int bad;
      load_default();
      in_vec   = {13'sd16, 13'sd16};
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      in_vec   = {13'sd100, -13'sd100};
      in_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (out_vec !== {16'hff7e, 16'h0023} || in_ready !== 1'b0 || out_valid !== 1'b1)
            bad++;
         @(negedge clk);
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL backpressure_hold: got %0d bad cycles (out_vec %h) want 0", bad, out_vec);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL backpressure_release: got in_ready %b out_valid %b want 1 0",
                  in_ready, out_valid);
      end
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1) begin
         fails++; $display("FAIL backpressure_no_accept: got in_ready %b want 1", in_ready);
      end
   endtask

   task automatic test_back_to_back;
      int t[8];
      int n;
      int bad;
      int w;
      in_vec    = {13'sd16, 13'sd16};
      in_valid  = 1'b1;
      out_ready = 1'b1;
      n   = 0;
      bad = 0;
      for (int i = 0; i < 14; i++) begin
         if (in_ready && n < 8) begin
            t[n] = i;
            n++;
         end
         if (out_valid && out_vec !== {16'hff7e, 16'h0023}) bad++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      tests++;
      if (n !== 4) begin
         fails++; $display("FAIL b2b_count: got %0d accepts want 4", n);
      end
      for (int i = 1; i < n; i++) begin
         tests++;
         if (t[i] - t[i-1] !== 4) begin
            fails++; $display("FAIL b2b_interval: got %0d want 4", t[i] - t[i-1]);
         end
      end
      tests++;
      if (bad !== 0) begin
         fails++; $display("FAIL b2b_out_vec: got %0d bad results want 0", bad);
      end
      w = 0;
      while (!in_ready && w < 10) begin
         @(negedge clk);
         w++;
      end
      out_ready = 1'b0;
   endtask

   task automatic test_coef_gating;
      logic [31:0] res;
      int lat;
      in_vec   = {13'sd16, 13'sd16};
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      write_coef(2'd0, 13'sd100);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      tests++;
      if (out_vec !== {16'hff7e, 16'h0023}) begin
         fails++; $display("FAIL gating_in_flight: got %h want ff7e0023", out_vec);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      run_vec(13'sd16, 13'sd0, res, lat);
      tests++;
      if (res !== {16'h0032, 16'hfffe}) begin
         fails++; $display("FAIL gating_reread: got %h want 0032fffe", res);
      end
      // Coefficient write and vector accept share one edge.
      coef_we   = 1'b1;
      coef_addr = 2'd0;
      coef_data = 13'sd16;
      in_vec    = {13'sd16, 13'sd16};
      in_valid  = 1'b1;
      @(negedge clk);
      coef_we  = 1'b0;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      tests++;
      if (out_vec !== {16'hff7e, 16'h0035}) begin
         fails++; $display("FAIL gating_same_edge: got %h want ff7e0035", out_vec);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic [31:0] res;
      int lat;
      load_default();
      in_vec   = {13'sd16, 13'sd16};
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      #1 rst = 1'b1;
      #1;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_vec !== 32'h0) begin
         fails++;
         $display("FAIL rst_in_done: got out_valid %b in_ready %b out_vec %h want 0 0 0",
                  out_valid, in_ready, out_vec);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      load_default();
      in_vec   = {13'sd16, 13'sd16};
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         fails++;
         $display("FAIL rst_in_mac: got out_valid %b in_ready %b want 0 0", out_valid, in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_vec(13'sd16, 13'sd16, res, lat);
      tests++;
      if (res !== 32'h0 || lat !== 3) begin
         fails++; $display("FAIL rst_cleared_coefs: got %h lat %0d want 00000000 lat 3", res, lat);
      end
   endtask

   task automatic test_generic;
      int lat;
      for (int i = 0; i < 4; i++) begin
         coef_we4   = 1'b1;
         coef_addr4 = 4'(i * 5);
         coef_data4 = 8'sd4;
         @(negedge clk);
      end
      coef_we4  = 1'b0;
      in_vec4   = {8'h80, 8'h7f, 8'hf8, 8'h04};
      in_valid4 = 1'b1;
      @(negedge clk);
      in_valid4 = 1'b0;
      in_vec4   = '0;
      lat = 1;
      while (!out_valid4 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      tests++;
      if (out_vec4 !== {12'hf80, 12'h07f, 12'hff8, 12'h004}) begin
         fails++; $display("FAIL generic_out_vec: got %h want f8007fff8004", out_vec4);
      end
      tests++;
      if (lat !== 5) begin
         fails++; $display("FAIL generic_latency: got %0d want 5", lat);
      end
      out_ready4 = 1'b1;
      @(negedge clk);
      out_ready4 = 1'b0;
   endtask

   initial begin
      #2;
      test_reset();
      test_defaults();
      test_saturation();
      test_backpressure();
      test_back_to_back();
      test_coef_gating();
      test_reset_mid();
      test_generic();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
